// File: rtl/writeback_regfile_pkg.sv
// Shared constants and types for the write-back stage and register file.
package writeback_regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic [4:0] ZERO_REG   = 5'd0;
  localparam logic       WB_SEL_ALU = 1'b0;
  localparam logic       WB_SEL_MEM = 1'b1;

  // WB-side fields of the MEM/WB pipeline register as seen by this stage.
  typedef struct packed {
    logic [DATA_W-1:0] readData;
    logic [DATA_W-1:0] aluResult;
    logic [ADDR_W-1:0] writeReg;
    logic              regWrite;
    logic              memToReg;
  } memWbT;
endpackage

// File: rtl/writeback_regfile_wb_select.sv
// Write-back value mux: load data or ALU result. Also used by forwarding.
module wb_select
  import writeback_regfile_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         memToReg,
  input  logic [W-1:0] readData,
  input  logic [W-1:0] aluResult,
  output logic [W-1:0] wbData
);
  // An X select falls through to the ALU result rather than propagating X.
  always_comb begin
    wbData = aluResult;
    if (memToReg == WB_SEL_MEM) wbData = readData;
  end
endmodule

// File: rtl/writeback_regfile.sv
// MEM/WB consumer: selects the write-back value, commits it to the 32x32
// register file, serves two ID read ports with write bypass, counts writes.
module writeback_regfile #(
  parameter int DATA_W   = writeback_regfile_pkg::DATA_W,
  parameter int ADDR_W   = writeback_regfile_pkg::ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] readData,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic              regWrite,
  input  logic              memToReg,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic [DATA_W-1:0] wbData,
  output logic [31:0]       writeCount
);
  import writeback_regfile_pkg::*;

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wrEn;
  logic              commit;

  wb_select #(.W(DATA_W)) uWbSel (
    .memToReg (memToReg),
    .readData (readData),
    .aluResult(aluResult),
    .wbData   (wbData)
  );

  // Explicit ==1'b1 so an X enable is treated as a bubble, never a write.
  assign wrEn   = (regWrite == 1'b1);
  assign commit = wrEn && (writeReg != ZERO_IDX);

  // Register array and retired-write counter; reset wins over a commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      writeCount <= '0;
    end else if (commit) begin
      regs[writeReg] <= wbData;
      writeCount     <= writeCount + 32'd1;
    end
  end

  // Read port 1: zero register, then same-cycle bypass, then storage.
  always_comb begin
    readData1 = regs[readReg1];
    if (readReg1 == ZERO_IDX)                 readData1 = '0;
    else if (wrEn && (writeReg == readReg1))  readData1 = wbData;
  end

  // Read port 2: identical priority to port 1.
  always_comb begin
    readData2 = regs[readReg2];
    if (readReg2 == ZERO_IDX)                 readData2 = '0;
    else if (wrEn && (writeReg == readReg2))  readData2 = wbData;
  end
endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench: directed scenarios then randomized traffic against an
// array-based reference model of the register file.
module tb_writeback_regfile;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] readData, aluResult;
  logic [4:0]  writeReg, readReg1, readReg2;
  logic        regWrite, memToReg;
  logic [31:0] readData1, readData2, wbData, writeCount;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mReg [32];
  logic [31:0] mCnt;

  always #5 clk = ~clk;

  writeback_regfile dut (
    .clk(clk), .rst(rst), .readData(readData), .aluResult(aluResult),
    .writeReg(writeReg), .regWrite(regWrite), .memToReg(memToReg),
    .readReg1(readReg1), .readReg2(readReg2), .readData1(readData1),
    .readData2(readData2), .wbData(wbData), .writeCount(writeCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expWb();
    return (memToReg === 1'b1) ? readData : aluResult;
  endfunction

  function automatic logic [31:0] expRead(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (regWrite === 1'b1 && writeReg == idx) return expWb();
    return mReg[idx];
  endfunction

  // Apply inputs mid-cycle, check the combinational view, then clock it.
  task automatic step(input logic r, input logic rw, input logic m2r, input logic [4:0] wr,
                      input logic [31:0] rd, input logic [31:0] alu,
                      input logic [4:0] r1, input logic [4:0] r2, input string tag);
    @(negedge clk);
    rst = r; regWrite = rw; memToReg = m2r; writeReg = wr;
    readData = rd; aluResult = alu; readReg1 = r1; readReg2 = r2;
    #1;
    check({tag, ".wb"},  wbData,     expWb());
    check({tag, ".rd1"}, readData1,  expRead(r1));
    check({tag, ".rd2"}, readData2,  expRead(r2));
    check({tag, ".cnt"}, writeCount, mCnt);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) mReg[i] = 32'd0;
      mCnt = 32'd0;
    end else if (rw === 1'b1 && wr != 5'd0) begin
      mReg[wr] = (m2r === 1'b1) ? rd : alu;
      mCnt = mCnt + 32'd1;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mReg[i] = 32'd0;
    mCnt = 32'd0;
    rst = 1'b1; regWrite = 1'b0; memToReg = 1'b0; writeReg = '0;
    readData = '0; aluResult = '0; readReg1 = '0; readReg2 = '0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, "rst");

    // Reset state: every register reads back as zero, counter zero.
    for (int i = 1; i < 32; i += 2) step(0, 0, 0, 0, 0, 0, 5'(i), 5'(i + 1), "rstState");
    check("rstCnt", writeCount, 32'd0);

    // ALU write, then read back.
    step(0, 1, 0, 8, 32'h0, 32'h0000_1234, 0, 0, "aluWr");
    step(0, 0, 0, 0, 0, 0, 8, 0, "aluRd");
    check("aluCnt", writeCount, 32'd1);

    // Load write; wbData carries the load value during the write cycle.
    step(0, 1, 1, 31, 32'hDEAD_BEEF, 32'h5, 0, 0, "ldWr");
    step(0, 0, 0, 0, 0, 0, 0, 31, "ldRd");
    check("ldVal", readData2, 32'hDEAD_BEEF);

    // Register 0 write is discarded and not counted.
    step(0, 1, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, "r0Wr");
    step(0, 0, 0, 0, 0, 0, 0, 0, "r0Rd");
    check("r0Cnt", writeCount, 32'd2);

    // Bypass: both ports see the new value before the edge.
    step(0, 1, 0, 9, 0, 32'h1, 0, 0, "byPre");
    step(0, 1, 0, 9, 0, 32'h77, 9, 9, "byWr");
    check("byP1", readData1, 32'h77);
    step(0, 0, 0, 0, 0, 0, 9, 9, "byRd");
    check("byStored", readData1, 32'h77);

    // Reset beats a same-cycle write; the following write commits.
    step(1, 1, 0, 4, 0, 32'hAA, 4, 0, "rpRst");
    step(0, 0, 0, 0, 0, 0, 4, 0, "rpRd0");
    check("rpCnt0", writeCount, 32'd0);
    step(0, 1, 0, 4, 0, 32'hAA, 0, 0, "rpWr");
    step(0, 0, 0, 0, 0, 0, 4, 0, "rpRd1");
    check("rpVal", readData1, 32'hAA);

    // Counter wrap via backdoor preload.
    @(negedge clk);
    force dut.writeCount = 32'hFFFF_FFFF;
    #1;
    release dut.writeCount;
    mCnt = 32'hFFFF_FFFF;
    step(0, 1, 0, 3, 0, 32'h33, 0, 0, "wrapWr");
    step(0, 0, 0, 0, 0, 0, 3, 0, "wrapRd");
    check("wrapCnt", writeCount, 32'd0);

    // Randomized traffic: occasional reset, X enables, bypass-biased reads.
    for (int n = 0; n < 400; n++) begin
      logic       r, rw, m2r;
      logic [4:0] wr, r1, r2;
      r   = ($urandom_range(0, 39) == 0);
      rw  = ($urandom_range(0, 19) == 0) ? 1'bx : 1'($urandom_range(0, 1));
      m2r = 1'($urandom_range(0, 1));
      wr  = 5'($urandom_range(0, 31));
      r1  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      r2  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      step(r, rw, m2r, wr, $urandom, $urandom, r1, r2, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
